wb_stage: RTL and testbench

Write-back stage of the five-stage pipeline, directly downstream of the memory-access stage. Owns the MEM→WB pipeline register and WB valid bit, the HI/LO registers and the CP0 STATUS/CAUSE/EPC registers. Commits the register-file write. Raises exception or ERET redirects, with a one-cycle cancel to flush all upstream stages.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cp0_regs.sv | 54 +++++
 rtl/wb_stage.sv | 90 +++++++++
 tb/tb_wb_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: MEM->WB bus layout, CP0 register map and exception codes.
// Bit offsets and the packed struct describe the same 143-bit bus.
package cpu_pkg;

  localparam int MEM_WB_W = 143;

  // Bit offsets of MEM_WB_bus fields (LSB of each field)
  localparam int PC_LSB         = 0;
  localparam int ERET_BIT       = 32;
  localparam int BRK_BIT        = 33;
  localparam int SYSCALL_BIT    = 34;
  localparam int CP0R_LSB       = 35;
  localparam int MFC0_BIT       = 43;
  localparam int MTC0_BIT       = 44;
  localparam int MFLO_BIT       = 45;
  localparam int MFHI_BIT       = 46;
  localparam int LO_WRITE_BIT   = 47;
  localparam int HI_WRITE_BIT   = 48;
  localparam int LO_RESULT_LSB  = 49;
  localparam int MEM_RESULT_LSB = 81;
  localparam int RF_WDEST_LSB   = 113;
  localparam int RF_WEN_BIT     = 118;
  localparam int FLAGS_LSB      = 119;
  localparam int RD_LSB         = 127;
  localparam int RT_LSB         = 132;
  localparam int RS_LSB         = 137;
  localparam int J_LINK_BIT     = 142;

  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_EXL   = 32'h0000_0002;

  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC0_0380;

  typedef struct packed {
    logic        j_link;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        cal_r;
    logic        cal_i;
    logic        store;
    logic        load;
    logic        jump;
    logic        mt;
    logic        mf;
    logic        lui;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        eret;
    logic [31:0] pc;
  } mem_wb_bus_t;

endpackage

// File: rtl/cp0_regs.sv
// CP0 STATUS/CAUSE/EPC with write masks, exception/ERET updates and read mux.
// Reads are combinational; updates land at the clock edge; never stalls.
module cp0_regs
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_en,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        exc_en,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        eret_en,
  output logic [31:0] rdata,
  output logic [31:0] epc
);

  logic [31:0] status;
  logic [31:0] cause;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status <= 32'd0;
      cause  <= 32'd0;
      epc    <= 32'd0;
    end else if (exc_en) begin
      epc    <= exc_epc;
      cause  <= {cause[31:7], exc_code, cause[1:0]};
      status <= status | STATUS_EXL;
    end else if (eret_en) begin
      status <= status & ~STATUS_EXL;
    end else if (mtc0_en) begin
      case (addr)
        CP0_STATUS: status <= wdata & STATUS_WMASK;
        // ExcCode is preserved: software may only touch the IP bits
        CP0_CAUSE:  cause  <= (cause & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
        CP0_EPC:    epc    <= wdata;
        default:    ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_STATUS: rdata = status;
      CP0_CAUSE:  rdata = cause;
      CP0_EPC:    rdata = epc;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB register, HI/LO, CP0 and exception/ERET redirect.
// One-cycle stage, always ready; a redirect cancels upstream and blocks capture that edge.
module wb_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                MEM_over,
  input  logic [MEM_WB_W-1:0] MEM_WB_bus,
  output logic                WB_allow_in,
  output logic                WB_valid,
  output logic                rf_wen,
  output logic [4:0]          rf_wdest,
  output logic [31:0]         rf_wdata,
  output logic [4:0]          WB_wdest,
  output logic                cancel,
  output logic                exc_valid,
  output logic [31:0]         exc_pc,
  output logic [31:0]         WB_pc
);

  mem_wb_bus_t bus_r;
  logic [31:0] hi, lo;
  logic [31:0] cp0_rdata, cp0_epc;
  logic        is_exc;

  assign WB_allow_in = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r    <= '0;
      WB_valid <= 1'b0;
    end else if (MEM_over && WB_allow_in && !cancel) begin
      bus_r    <= mem_wb_bus_t'(MEM_WB_bus);
      WB_valid <= 1'b1;
    end else begin
      WB_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (WB_valid) begin
      if (bus_r.hi_write) hi <= bus_r.mem_result;
      if (bus_r.lo_write) lo <= bus_r.lo_result;
    end
  end

  // syscall/break outrank eret when both are flagged
  assign is_exc = bus_r.syscall | bus_r.brk;

  cp0_regs u_cp0 (
    .clk      (clk),
    .resetn   (resetn),
    .mtc0_en  (WB_valid & bus_r.mtc0),
    .addr     (bus_r.cp0r_addr),
    .wdata    (bus_r.mem_result),
    .exc_en   (WB_valid & is_exc),
    .exc_code (bus_r.syscall ? EXC_SYS : EXC_BP),
    .exc_epc  (bus_r.pc),
    .eret_en  (WB_valid & bus_r.eret & ~is_exc),
    .rdata    (cp0_rdata),
    .epc      (cp0_epc)
  );

  always_comb begin
    rf_wdata = bus_r.mem_result;
    if (bus_r.mfhi)      rf_wdata = hi;
    else if (bus_r.mflo) rf_wdata = lo;
    else if (bus_r.mfc0) rf_wdata = cp0_rdata;
  end

  assign rf_wen    = WB_valid & bus_r.rf_wen;
  assign rf_wdest  = bus_r.rf_wdest;
  assign WB_wdest  = WB_valid ? bus_r.rf_wdest : 5'd0;
  assign exc_valid = WB_valid & (is_exc | bus_r.eret);
  assign exc_pc    = is_exc ? EXC_ENTRY : cp0_epc;
  assign cancel    = exc_valid;
  assign WB_pc     = bus_r.pc;

  logic unused_bus;
  assign unused_bus = ^{bus_r.j_link, bus_r.rs, bus_r.rt, bus_r.rd, bus_r.cal_r,
                        bus_r.cal_i, bus_r.store, bus_r.load, bus_r.jump,
                        bus_r.mt, bus_r.mf, bus_r.lui};

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, result select, HI/LO, CP0 access, syscall/eret/break.
module tb_wb_stage;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                MEM_over;
  logic [MEM_WB_W-1:0] MEM_WB_bus;
  logic                WB_allow_in, WB_valid, rf_wen, cancel, exc_valid;
  logic [4:0]          rf_wdest, WB_wdest;
  logic [31:0]         rf_wdata, exc_pc, WB_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .MEM_over   (MEM_over),
    .MEM_WB_bus (MEM_WB_bus),
    .WB_allow_in(WB_allow_in),
    .WB_valid   (WB_valid),
    .rf_wen     (rf_wen),
    .rf_wdest   (rf_wdest),
    .rf_wdata   (rf_wdata),
    .WB_wdest   (WB_wdest),
    .cancel     (cancel),
    .exc_valid  (exc_valid),
    .exc_pc     (exc_pc),
    .WB_pc      (WB_pc)
  );

  function automatic mem_wb_bus_t mk_mfc0(input logic [7:0] a);
    mem_wb_bus_t b = '0;
    b.rf_wen = 1'b1; b.rf_wdest = 5'd2; b.mfc0 = 1'b1; b.cp0r_addr = a;
    return b;
  endfunction

  function automatic mem_wb_bus_t mk_mtc0(input logic [7:0] a, input logic [31:0] d);
    mem_wb_bus_t b = '0;
    b.mtc0 = 1'b1; b.cp0r_addr = a; b.mem_result = d;
    return b;
  endfunction

  // Present one instruction for one edge; returns #1 after the capturing edge.
  task automatic issue(input mem_wb_bus_t b);
    MEM_over   = 1'b1;
    MEM_WB_bus = b;
    @(posedge clk); #1;
    MEM_over   = 1'b0;
    MEM_WB_bus = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; MEM_over = 1'b0; MEM_WB_bus = '0;
    #3;
    n_cmp++; if (WB_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", WB_valid); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if ({cancel, exc_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_redirect got %b want 00", {cancel, exc_valid}); end
    n_cmp++; if (WB_allow_in !== 1'b1) begin n_fail++; $display("FAIL reset_allow_in got %b want 1", WB_allow_in); end
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    idle();
  endtask

  task automatic test_add();
    mem_wb_bus_t b = '0;
    b.cal_r = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd5; b.mem_result = 32'h1234; b.pc = 32'h40;
    issue(b);
    n_cmp++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL add_rf_wen got %b want 1", rf_wen); end
    n_cmp++; if (rf_wdest !== 5'd5) begin n_fail++; $display("FAIL add_wdest got %0d want 5", rf_wdest); end
    n_cmp++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL add_wdata got %h want 00001234", rf_wdata); end
    n_cmp++; if (WB_wdest !== 5'd5) begin n_fail++; $display("FAIL add_WB_wdest got %0d want 5", WB_wdest); end
    n_cmp++; if (WB_pc !== 32'h40) begin n_fail++; $display("FAIL add_pc got %h want 00000040", WB_pc); end
    n_cmp++; if (exc_valid !== 1'b0) begin n_fail++; $display("FAIL add_no_exc got %b want 0", exc_valid); end
    idle();
    n_cmp++; if ({WB_valid, rf_wen, WB_wdest} !== 7'd0) begin n_fail++; $display("FAIL add_drain got %b want 0", {WB_valid, rf_wen, WB_wdest}); end
  endtask

  task automatic test_hilo();
    mem_wb_bus_t b = '0;
    b.hi_write = 1'b1; b.lo_write = 1'b1; b.mem_result = 32'hA; b.lo_result = 32'hB;
    issue(b);
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL mult_rf_wen got %b want 0", rf_wen); end
    b = '0; b.rf_wen = 1'b1; b.rf_wdest = 5'd3; b.mfhi = 1'b1; b.mem_result = 32'hFFFF;
    issue(b);
    n_cmp++; if (rf_wdata !== 32'hA) begin n_fail++; $display("FAIL mfhi got %h want 0000000a", rf_wdata); end
    b.mfhi = 1'b0; b.mflo = 1'b1;
    issue(b);
    n_cmp++; if (rf_wdata !== 32'hB) begin n_fail++; $display("FAIL mflo got %h want 0000000b", rf_wdata); end
  endtask

  task automatic test_invalid();
    mem_wb_bus_t b = '0;
    b.hi_write = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd9; b.mem_result = 32'hDEAD; b.syscall = 1'b1;
    MEM_over = 1'b0; MEM_WB_bus = b;
    idle(); idle();
    n_cmp++; if ({WB_valid, rf_wen, exc_valid} !== 3'b000) begin n_fail++; $display("FAIL invalid_quiet got %b want 000", {WB_valid, rf_wen, exc_valid}); end
    MEM_WB_bus = '0;
    b = '0; b.rf_wen = 1'b1; b.mfhi = 1'b1;
    issue(b);
    n_cmp++; if (rf_wdata !== 32'hA) begin n_fail++; $display("FAIL invalid_hi_kept got %h want 0000000a", rf_wdata); end
  endtask

  task automatic test_cp0_rw();
    issue(mk_mtc0(CP0_STATUS, 32'hFFFF_FFFF));
    issue(mk_mfc0(CP0_STATUS));
    n_cmp++; if (rf_wdata !== 32'h0000_FF03) begin n_fail++; $display("FAIL status_mask got %h want 0000ff03", rf_wdata); end
    issue(mk_mtc0(CP0_CAUSE, 32'hFFFF_FFFF));
    issue(mk_mfc0(CP0_CAUSE));
    n_cmp++; if (rf_wdata !== 32'h0000_0300) begin n_fail++; $display("FAIL cause_mask got %h want 00000300", rf_wdata); end
    issue(mk_mtc0(CP0_EPC, 32'h1357_9BDF));
    issue(mk_mfc0(CP0_EPC));
    n_cmp++; if (rf_wdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL epc_rw got %h want 13579bdf", rf_wdata); end
    issue(mk_mtc0({5'd15, 3'd0}, 32'hFFFF_FFFF));
    issue(mk_mfc0({5'd15, 3'd0}));
    n_cmp++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want 00000000", rf_wdata); end
    issue(mk_mtc0(CP0_STATUS, 32'h0000_FF01));
    issue(mk_mfc0(CP0_STATUS));
    n_cmp++; if (rf_wdata !== 32'h0000_FF01) begin n_fail++; $display("FAIL status_exl_clear got %h want 0000ff01", rf_wdata); end
  endtask

  task automatic test_syscall();
    mem_wb_bus_t b = '0;
    mem_wb_bus_t nxt = '0;
    b.syscall = 1'b1; b.pc = 32'h80;
    nxt.rf_wen = 1'b1; nxt.rf_wdest = 5'd7; nxt.mem_result = 32'h77; nxt.pc = 32'h84;
    issue(b);
    MEM_over = 1'b1; MEM_WB_bus = nxt;
    n_cmp++; if (exc_valid !== 1'b1) begin n_fail++; $display("FAIL sys_exc_valid got %b want 1", exc_valid); end
    n_cmp++; if (exc_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL sys_exc_pc got %h want bfc00380", exc_pc); end
    n_cmp++; if (cancel !== 1'b1) begin n_fail++; $display("FAIL sys_cancel got %b want 1", cancel); end
    idle();
    MEM_over = 1'b0; MEM_WB_bus = '0;
    n_cmp++; if ({WB_valid, cancel, rf_wen} !== 3'b000) begin n_fail++; $display("FAIL sys_flush got %b want 000", {WB_valid, cancel, rf_wen}); end
    issue(mk_mfc0(CP0_EPC));
    n_cmp++; if (rf_wdata !== 32'h80) begin n_fail++; $display("FAIL sys_epc got %h want 00000080", rf_wdata); end
    issue(mk_mfc0(CP0_CAUSE));
    n_cmp++; if (rf_wdata[6:2] !== EXC_SYS) begin n_fail++; $display("FAIL sys_exccode got %0d want 8", rf_wdata[6:2]); end
    issue(mk_mfc0(CP0_STATUS));
    n_cmp++; if (rf_wdata !== 32'h0000_FF03) begin n_fail++; $display("FAIL sys_exl got %h want 0000ff03", rf_wdata); end
  endtask

  task automatic test_eret_break();
    mem_wb_bus_t b = '0;
    b.eret = 1'b1; b.pc = 32'hBFC0_0380;
    issue(b);
    n_cmp++; if ({exc_valid, cancel} !== 2'b11) begin n_fail++; $display("FAIL eret_redirect got %b want 11", {exc_valid, cancel}); end
    n_cmp++; if (exc_pc !== 32'h80) begin n_fail++; $display("FAIL eret_pc got %h want 00000080", exc_pc); end
    idle();
    issue(mk_mfc0(CP0_STATUS));
    n_cmp++; if (rf_wdata !== 32'h0000_FF01) begin n_fail++; $display("FAIL eret_exl got %h want 0000ff01", rf_wdata); end
    b = '0; b.brk = 1'b1; b.pc = 32'h100;
    issue(b);
    n_cmp++; if (exc_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL brk_exc_pc got %h want bfc00380", exc_pc); end
    idle();
    issue(mk_mfc0(CP0_CAUSE));
    n_cmp++; if (rf_wdata[6:2] !== EXC_BP) begin n_fail++; $display("FAIL brk_exccode got %0d want 9", rf_wdata[6:2]); end
    issue(mk_mfc0(CP0_EPC));
    n_cmp++; if (rf_wdata !== 32'h100) begin n_fail++; $display("FAIL brk_epc got %h want 00000100", rf_wdata); end
    b = '0; b.syscall = 1'b1; b.eret = 1'b1; b.pc = 32'h200;
    issue(b);
    n_cmp++; if (exc_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL sys_over_eret got %h want bfc00380", exc_pc); end
    idle();
  endtask

  task automatic test_reset_midstream();
    mem_wb_bus_t b = '0;
    b.cal_r = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd5; b.mem_result = 32'h1234;
    issue(b);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({WB_valid, rf_wen, WB_wdest} !== 7'd0) begin n_fail++; $display("FAIL mid_reset_async got %b want 0", {WB_valid, rf_wen, WB_wdest}); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset_wdata got %h want 00000000", rf_wdata); end
    @(negedge clk); resetn = 1'b1;
    idle();
    n_cmp++; if ({WB_valid, rf_wen, cancel, exc_valid} !== 4'd0) begin n_fail++; $display("FAIL post_release got %b want 0", {WB_valid, rf_wen, cancel, exc_valid}); end
    b = '0; b.syscall = 1'b1; b.pc = 32'h300;
    issue(b);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({exc_valid, cancel} !== 2'b00) begin n_fail++; $display("FAIL reset_drops_redirect got %b want 00", {exc_valid, cancel}); end
    @(negedge clk); resetn = 1'b1;
    idle();
    b = '0; b.rf_wen = 1'b1; b.mfhi = 1'b1;
    issue(b);
    n_cmp++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL hi_after_reset got %h want 00000000", rf_wdata); end
    issue(mk_mfc0(CP0_EPC));
    n_cmp++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL epc_after_reset got %h want 00000000", rf_wdata); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hilo();
    test_invalid();
    test_cp0_rw();
    test_syscall();
    test_eret_break();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
